parity_serial_tx: RTL and testbench
===================================

// Module: parity_serial_tx
// PURPOSE
// - Transmit end of the parity-protected 4-bit word link; the checker on that link validates
//   bits with reduction-XOR / known-value assertions.
// - Accepts parallel words on a valid/ready handshake and buffers them in a small FIFO.
// - Serializes each word as a frame: start(0), data LSB-first, parity, stop(1).
// - Every output is a registered, reset-defined 0/1 from the first cycle after reset; no X/Z.
// PARAMETERS
// - DATA_W      4  data bits per word
// - DEPTH       4  FIFO entries, power of 2, >=2
// - BIT_CYCLES  2  clk cycles each serial bit is held, >=1
// - PARITY_ODD  0  0: parity bit = ^data (even total ones); 1: parity bit = ~^data
// PORTS
// - clk         in   1                 single clock, all logic on posedge
// - rst         in   1                 synchronous, active-high reset
// - in_valid    in   1                 word offered
// - in_data     in   DATA_W            word to send; sampled only on handshake
// - in_ready    out  1                 FIFO not full
// - tx          out  1                 serial line, idle high
// - busy        out  1                 frame in progress (START..STOP)
// - fifo_count  out  $clog2(DEPTH+1)   words buffered, not counting the frame in flight
// BEHAVIOUR
// - Reset state (rst=1 at posedge): tx=1, busy=0, fifo_count=0, in_ready=1, FSM=IDLE,
//   bit/baud counters=0, FIFO pointers=0.
// - Reset mid-frame: frame aborts, FIFO flushes, tx=1 from the next cycle.
// - Push: in_valid && in_ready at a posedge. in_ready = (fifo_count != DEPTH), from registered
//   count only. When full, a same-cycle pop does NOT make the FIFO ready.
// - FSM states: IDLE, START, DATA, PARITY, STOP.
//   - IDLE: when fifo_count != 0, pop head into shift reg, compute parity, go START.
//   - START: tx=0 for BIT_CYCLES, then go DATA.
//   - DATA: tx=shift[0] for BIT_CYCLES per bit, shift right; after DATA_W bits go PARITY.
//   - PARITY: tx=parity for BIT_CYCLES, then go STOP.
//   - STOP: tx=1 for BIT_CYCLES. Then, if FIFO non-empty, pop and go START (no idle gap);
//     else go IDLE.
// - Latency: word pushed at edge N into empty FIFO with FSM idle -> pop at edge N+1,
//   start bit on tx from cycle after edge N+1.
// - Frame length: (DATA_W+3)*BIT_CYCLES cycles.
// - busy=1 in START..STOP, 0 in IDLE. tx is registered.
// - Same-cycle push and pop with 0<count<DEPTH: count unchanged, pointers both advance.
// - Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty come from
//   fifo_count only.
// - Baud counter: $clog2(BIT_CYCLES+1) bits, reloads at every bit boundary.
//   BIT_CYCLES=1 means one bit per cycle.
// - Parity is computed once at pop from the popped word, never from in_data.
// STRUCTURE
// - parity_tx_pkg: typedef enum logic [2:0] tx_state_e {IDLE,START,DATA,PARITY,STOP};
//   localparams TX_IDLE_LVL=1'b1, START_LVL=1'b0, STOP_LVL=1'b1;
//   function calc_parity(data, odd).
// - One sub-module: sync_fifo #(DATA_W, DEPTH), with push/pop/count, single clk,
//   synchronous rst.
// - Top holds the FSM, baud counter, bit counter, shift register and tx register.
// TESTING
// - Reset: rst=1 for 2 cycles -> tx=1, busy=0, in_ready=1, fifo_count=0.
//   Assert !$isunknown({tx,busy,in_ready,fifo_count}) on every posedge after the first reset.
// - Single word 4'b1011, BIT_CYCLES=2, even parity -> tx = 0,1,1,0,1,1,1, each bit for
//   2 cycles (14-cycle frame); busy high exactly 14 cycles; then tx=1, busy=0.
// - Odd parity, word 4'b0000 -> parity bit 1. Even parity, word 4'b0000 -> parity bit 0.
// - Burst: in_valid held with 6 words, BIT_CYCLES=1 -> in_ready drops when fifo_count=4.
//   All 6 frames sent back-to-back with stop followed directly by start. Monitor decodes the
//   words in order, and the XOR of data+parity per frame matches PARITY_ODD.
// - Full plus pop: FIFO full while STOP finishes and in_valid=1 -> no push that cycle;
//   push occurs the cycle after, with count 3->4.
// - rst=1 during the DATA bit 2 of frame 1 with 2 words queued -> tx=1 and fifo_count=0 next
//   cycle; no partial frame continues; a new word after reset sends a clean full frame.

Source files
------------

// File: rtl/parity_tx_pkg.sv
// Shared types, line levels and the parity helper for the parity-protected serial transmitter.
package parity_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic TX_IDLE_LVL = 1'b1;
  localparam logic START_LVL   = 1'b0;
  localparam logic STOP_LVL    = 1'b1;

  // Parity bit for a word; the word is zero-extended, so unused upper bits do not affect the XOR.
  // odd=0 gives even total ones over data+parity, odd=1 gives odd total ones.
  function automatic logic calc_parity(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_serial_tx_fifo.sv
// sync_fifo: small circular word buffer; full/empty come only from the registered occupancy.
module sync_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_not_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_not_full;
  logic [CW-1:0]     w_count_nxt;
  logic              w_do_push;
  logic              w_do_pop;

  // Qualify requests against registered state so a same-cycle pop never unblocks a full FIFO
  always_comb begin
    w_do_push   = i_push && r_not_full;
    w_do_pop    = i_pop && (r_count != '0);
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage, wrapping pointers, occupancy and the registered not-full flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_not_full <= 1'b1;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count    <= w_count_nxt;
      r_not_full <= (w_count_nxt != FULL_CNT);
    end
  end

  assign o_data     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_not_full = r_not_full;

endmodule

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: buffers 4-bit words and sends each as start, data LSB-first, parity, stop.
module parity_serial_tx
  import parity_tx_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int DEPTH      = 4,
  parameter int BIT_CYCLES = 2,
  parameter int PARITY_ODD = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int BW = $clog2(BIT_CYCLES + 1);
  localparam int NW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(BIT_CYCLES - 1);
  localparam logic [NW-1:0] LAST_BIT    = NW'(DATA_W - 1);
  localparam logic          ODD_SEL     = (PARITY_ODD != 0);

  tx_state_e                    r_state;
  logic [BW-1:0]                r_baud;
  logic [NW-1:0]                r_bit;
  logic [DATA_W-1:0]            r_shift;
  logic                         r_parity;
  logic                         r_tx;
  logic                         r_busy;

  logic [DATA_W-1:0]            w_fifo_data;
  logic [$clog2(DEPTH+1)-1:0]   w_fifo_count;
  logic                         w_fifo_not_full;
  logic                         w_bit_end;
  logic                         w_pop;
  logic [DATA_W-1:0]            w_shift_nxt;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (in_valid),
    .i_data     (in_data),
    .i_pop      (w_pop),
    .o_data     (w_fifo_data),
    .o_count    (w_fifo_count),
    .o_not_full (w_fifo_not_full)
  );

  // Pop decision: from IDLE, or at the last stop-bit cycle to chain frames without an idle gap
  always_comb begin
    w_bit_end   = (r_baud == '0);
    w_shift_nxt = r_shift >> 1;
    w_pop       = 1'b0;
    if (w_fifo_count != '0) begin
      w_pop = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
    end else begin
      w_pop = 1'b0;
    end
  end

  // Frame sequencer: state, baud and bit counters, shift register and the registered line
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_tx     <= TX_IDLE_LVL;
      r_busy   <= 1'b0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift  <= w_fifo_data;
            r_parity <= calc_parity(32'(w_fifo_data), ODD_SEL);
            r_state  <= START;
            r_tx     <= START_LVL;
            r_busy   <= 1'b1;
            r_baud   <= BAUD_RELOAD;
            r_bit    <= '0;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
            r_baud  <= BAUD_RELOAD;
            r_bit   <= '0;
          end else begin
            r_baud <= r_baud - BW'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baud <= BAUD_RELOAD;
            if (r_bit == LAST_BIT) begin
              r_state <= PARITY;
              r_tx    <= r_parity;
            end else begin
              r_bit   <= r_bit + NW'(1);
              r_shift <= w_shift_nxt;
              r_tx    <= w_shift_nxt[0];
            end
          end else begin
            r_baud <= r_baud - BW'(1);
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_state <= STOP;
            r_tx    <= STOP_LVL;
            r_baud  <= BAUD_RELOAD;
          end else begin
            r_baud <= r_baud - BW'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift  <= w_fifo_data;
              r_parity <= calc_parity(32'(w_fifo_data), ODD_SEL);
              r_state  <= START;
              r_tx     <= START_LVL;
              r_busy   <= 1'b1;
              r_baud   <= BAUD_RELOAD;
              r_bit    <= '0;
            end else begin
              r_state <= IDLE;
              r_tx    <= TX_IDLE_LVL;
              r_busy  <= 1'b0;
              r_baud  <= '0;
            end
          end else begin
            r_baud <= r_baud - BW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= TX_IDLE_LVL;
          r_busy  <= 1'b0;
          r_baud  <= '0;
          r_bit   <= '0;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign in_ready   = w_fifo_not_full;
  assign fifo_count = w_fifo_count;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Scoreboard bench: two transmitters (A: 2 cycles/bit even parity, B: 1 cycle/bit odd parity).
module tb_parity_serial_tx;

  localparam int DW    = 4;
  localparam int BC_A  = 2;
  localparam int BC_B  = 1;
  localparam int ODD_A = 0;
  localparam int ODD_B = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       val_a = 1'b0, val_b = 1'b0;
  logic [3:0] dat_a = 4'd0, dat_b = 4'd0;
  logic       rdy_a, rdy_b, tx_a, tx_b, busy_a, busy_b;
  logic [2:0] cnt_a, cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] q_a[$];
  logic [3:0] q_b[$];

  int   pos[2]      = '{-1, -1};
  int   idle_run[2] = '{1, 1};
  int   b2b[2]      = '{0, 0};
  int   frames[2]   = '{0, 0};
  logic busy_ok[2];
  logic line_s[2][14];

  int   stall_cycles = 0;
  int   refill_seen  = 0;
  logic seen_rst     = 1'b0;

  always #5 clk = ~clk;

  parity_serial_tx #(.DATA_W(4), .DEPTH(4), .BIT_CYCLES(BC_A), .PARITY_ODD(ODD_A)) dut_a (
    .clk(clk), .rst(rst), .in_valid(val_a), .in_data(dat_a), .in_ready(rdy_a),
    .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a)
  );

  parity_serial_tx #(.DATA_W(4), .DEPTH(4), .BIT_CYCLES(BC_B), .PARITY_ODD(ODD_B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(val_b), .in_data(dat_b), .in_ready(rdy_b),
    .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, req, $time);
    end
  endtask

  // Line level at sample p of a frame, built from the frame layout rules.
  function automatic logic frame_bit(input logic [3:0] d, input int bc, input int odd, input int p);
    int s;
    s = p / bc;
    if (s == 0) return 1'b0;
    else if (s <= DW) return d[s-1];
    else if (s == DW + 1) return (^d) ^ (odd != 0);
    else return 1'b1;
  endfunction

  // Monitor: decodes frames off the line and compares against the scoreboard queue.
  task automatic mon_step(input int k);
    logic t, b, shape_ok, got_p;
    logic [3:0] got_d, exp_d;
    int bc, odd, flen;
    bc   = (k == 0) ? BC_A : BC_B;
    odd  = (k == 0) ? ODD_A : ODD_B;
    flen = (DW + 3) * bc;
    t    = (k == 0) ? tx_a : tx_b;
    b    = (k == 0) ? busy_a : busy_b;
    if (rst) begin
      pos[k]      = -1;
      idle_run[k] = 1;
      return;
    end
    if (pos[k] < 0) begin
      if (t == 1'b0) begin
        if (idle_run[k] == 0) b2b[k]++;
        pos[k]     = 0;
        busy_ok[k] = 1'b1;
      end else begin
        idle_run[k]++;
        check($sformatf("busy_when_idle_%0d", k), 32'(b), 32'd0);
      end
    end
    if (pos[k] >= 0) begin
      line_s[k][pos[k]] = t;
      busy_ok[k] = busy_ok[k] & b;
      pos[k]++;
      if (pos[k] == flen) begin
        shape_ok = busy_ok[k];
        for (int s = 0; s < DW + 3; s++)
          for (int c = 1; c < bc; c++)
            if (line_s[k][s*bc+c] !== line_s[k][s*bc]) shape_ok = 1'b0;
        if (line_s[k][0] !== 1'b0 || line_s[k][(DW+2)*bc] !== 1'b1) shape_ok = 1'b0;
        for (int i = 0; i < DW; i++) got_d[i] = line_s[k][(i+1)*bc];
        got_p = line_s[k][(DW+1)*bc];
        frames[k]++;
        check($sformatf("frame_shape_%0d", k), 32'(shape_ok), 32'd1);
        if (((k == 0) ? q_a.size() : q_b.size()) == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame_%0d: got data %0h with nothing queued", k, got_d);
        end else begin
          exp_d = (k == 0) ? q_a.pop_front() : q_b.pop_front();
          check($sformatf("frame_data_%0d", k), 32'(got_d), 32'(exp_d));
          check($sformatf("frame_parity_%0d", k), 32'(got_p), 32'((^exp_d) ^ (odd != 0)));
          check($sformatf("frame_xor_%0d", k), 32'(^{got_d, got_p}), 32'(odd));
        end
        pos[k]      = -1;
        idle_run[k] = 0;
      end
    end
  endtask

  // Line monitors, one per transmitter, sampling away from the active edge
  always @(negedge clk) mon_step(0);
  always @(negedge clk) mon_step(1);

  // Outputs must be known on every edge once the first reset has been applied
  always @(posedge clk) begin
    if (seen_rst)
      check("no_x", 32'($isunknown({tx_a, busy_a, rdy_a, cnt_a, tx_b, busy_b, rdy_b, cnt_b})), 32'd0);
    if (rst) seen_rst = 1'b1;
  end

  // Offer a word until accepted; checks ready against occupancy and the full-then-refill step.
  task automatic push_word(input int k, input logic [3:0] d);
    logic r, prev_r, refill;
    logic [2:0] c;
    int tries;
    tries  = 0;
    prev_r = 1'b1;
    r      = 1'b0;
    while (r == 1'b0) begin
      if (k == 0) begin val_a = 1'b1; dat_a = d; r = rdy_a; c = cnt_a; end
      else        begin val_b = 1'b1; dat_b = d; r = rdy_b; c = cnt_b; end
      check($sformatf("ready_vs_count_%0d", k), 32'(r), 32'(c != 3'd4));
      refill = r && !prev_r;
      if (refill) check($sformatf("count_before_refill_%0d", k), 32'(c), 32'd3);
      if (!r) stall_cycles++;
      @(negedge clk);
      if (r) begin
        if (k == 0) q_a.push_back(d); else q_b.push_back(d);
        if (refill) begin
          refill_seen++;
          check($sformatf("count_after_refill_%0d", k), 32'((k == 0) ? cnt_a : cnt_b), 32'd4);
        end
      end else begin
        tries++;
        if (tries > 200) begin
          n_cmp++;
          n_bad++;
          $display("FAIL push_timeout_%0d: got no ready after %0d cycles required ready", k, tries);
          r = 1'b1;
        end
      end
      prev_r = r;
    end
    if (k == 0) val_a = 1'b0; else val_b = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    logic done;
    done = 1'b0;
    n    = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      if ((((k == 0) ? q_a.size() : q_b.size()) == 0) && pos[k] < 0 &&
          (((k == 0) ? busy_a : busy_b) == 1'b0)) done = 1'b1;
      else if (n > 3000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain_timeout_%0d: got %0d words pending required 0", k,
                 (k == 0) ? q_a.size() : q_b.size());
        done = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : global_bound
    #500000;
    $display("FAIL global_timeout: got no finish required finish by 500000");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [3:0] w[6];
    logic       line_ok;
    int         b0, f0;

    // Reset for two edges
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx_a", 32'(tx_a), 32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_ready_a", 32'(rdy_a), 32'd1);
    check("rst_count_a", 32'(cnt_a), 32'd0);
    check("rst_tx_b", 32'(tx_b), 32'd1);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_ready_b", 32'(rdy_b), 32'd1);
    check("rst_count_b", 32'(cnt_b), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single word 1011 on A, traced sample by sample
    push_word(0, 4'b1011);
    check("latency_tx_before_pop", 32'(tx_a), 32'd1);
    check("latency_count_before_pop", 32'(cnt_a), 32'd1);
    for (int p = 0; p < (DW + 3) * BC_A; p++) begin
      @(negedge clk);
      check($sformatf("trace_tx_p%0d", p), 32'(tx_a), 32'(frame_bit(4'b1011, BC_A, ODD_A, p)));
      check($sformatf("trace_busy_p%0d", p), 32'(busy_a), 32'd1);
    end
    @(negedge clk);
    check("after_frame_tx", 32'(tx_a), 32'd1);
    check("after_frame_busy", 32'(busy_a), 32'd0);
    wait_idle(0);

    // All-zero word on both parities
    push_word(0, 4'b0000);
    push_word(1, 4'b0000);
    wait_idle(0);
    wait_idle(1);

    // Random words with random gaps on both
    for (int i = 0; i < 8; i++) begin
      push_word(i % 2, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    wait_idle(0);
    wait_idle(1);

    // Burst of six on B with in_valid held: fills, refills after a pop, frames chain
    b0 = b2b[1];
    stall_cycles = 0;
    refill_seen  = 0;
    for (int i = 0; i < 6; i++) w[i] = 4'($urandom_range(0, 15));
    for (int i = 0; i < 6; i++) push_word(1, w[i]);
    wait_idle(1);
    check("burst_back_to_back", 32'(b2b[1] - b0), 32'd5);
    check("burst_stalled_when_full", 32'(stall_cycles > 0), 32'd1);
    check("burst_refill_seen", 32'(refill_seen > 0), 32'd1);

    // Burst of six on A as well
    b0 = b2b[0];
    for (int i = 0; i < 6; i++) push_word(0, 4'($urandom_range(0, 15)));
    wait_idle(0);
    check("burst_a_back_to_back", 32'(b2b[0] - b0), 32'd5);

    // Reset during data bit 2 of a frame with two words queued
    for (int i = 0; i < 3; i++) w[i] = 4'($urandom_range(0, 15));
    push_word(0, w[0]);
    push_word(0, w[1]);
    push_word(0, w[2]);
    check("pre_reset_start_bit", 32'(tx_a), 32'd0);
    check("pre_reset_count", 32'(cnt_a), 32'd2);
    repeat (5) @(negedge clk);
    check("pre_reset_data_bit2", 32'(tx_a), 32'(w[0][2]));
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_tx", 32'(tx_a), 32'd1);
    check("mid_reset_count", 32'(cnt_a), 32'd0);
    check("mid_reset_busy", 32'(busy_a), 32'd0);
    check("mid_reset_ready", 32'(rdy_a), 32'd1);
    q_a.delete();
    @(negedge clk);
    rst = 1'b0;
    line_ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) line_ok = 1'b0;
    end
    check("post_reset_line_quiet", 32'(line_ok), 32'd1);
    f0 = frames[0];
    push_word(0, 4'($urandom_range(0, 15)));
    wait_idle(0);
    check("post_reset_one_frame", 32'(frames[0] - f0), 32'd1);

    check("final_queue_a_empty", 32'(q_a.size()), 32'd0);
    check("final_queue_b_empty", 32'(q_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
